// File: rtl/vc_arbiter.sv
// Two-VC arbiter: pops show-ahead VC FIFOs into a registered output stage with head-of-line pause.
// Define VC_ARB_WRR_EN for WEIGHT:1 weighted round-robin; the default build is strict VC0 priority.
module vc_arbiter #(
  parameter int BITNUMBER = 5,
  parameter int WEIGHT    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [BITNUMBER-1:0] vc0_data,
  input  logic [BITNUMBER-1:0] vc1_data,
  input  logic                 d0_pause,
  input  logic                 d1_pause,
  output logic                 vc0_pop,
  output logic                 vc1_pop,
  output logic                 valid_out,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 active_vc
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SERVE_VC0 = 2'b01,
    SERVE_VC1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   elig0, elig1, grant0, grant1;

`ifdef VC_ARB_WRR_EN
  logic [3:0] wcnt, wcnt_nxt;
`endif

  // Eligibility looks at the destination bit of each VC's current head word.
  assign elig0 = !vc0_empty && !(vc0_data[BITNUMBER-1] ? d1_pause : d0_pause);
  assign elig1 = !vc1_empty && !(vc1_data[BITNUMBER-1] ? d1_pause : d0_pause);

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = IDLE;
`ifdef VC_ARB_WRR_EN
    wcnt_nxt  = 4'd0;
`endif
    if (elig0 && elig1) begin
`ifdef VC_ARB_WRR_EN
      if (wcnt < 4'(WEIGHT)) grant0 = 1'b1;
      else                   grant1 = 1'b1;
`else
      grant0 = 1'b1;
`endif
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
    if (!reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
    if (grant0) begin
      state_nxt = SERVE_VC0;
`ifdef VC_ARB_WRR_EN
      wcnt_nxt  = (wcnt == 4'hf) ? wcnt : wcnt + 4'd1;
`endif
    end else if (grant1) begin
      state_nxt = SERVE_VC1;
    end
  end

  assign vc0_pop   = grant0;
  assign vc1_pop   = grant1;
  // Every grant leaves a SERVE state, so a non-IDLE state means data_out holds a fresh word.
  assign valid_out = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data_out  <= '0;
      active_vc <= 1'b0;
`ifdef VC_ARB_WRR_EN
      wcnt      <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
`ifdef VC_ARB_WRR_EN
      wcnt  <= wcnt_nxt;
`endif
      if (grant0) begin
        data_out  <= vc0_data;
        active_vc <= 1'b0;
      end else if (grant1) begin
        data_out  <= vc1_data;
        active_vc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomized and directed bench for vc_arbiter against a streak-counting reference model.
// Expectations follow VC_ARB_WRR_EN the same way the design build does.
module tb_vc_arbiter;
  localparam int BN = 5;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          vc0_empty, vc1_empty, d0_pause, d1_pause;
  logic [BN-1:0] vc0_data, vc1_data;
  logic          vc0_pop, vc1_pop, valid_out, active_vc;
  logic [BN-1:0] data_out;

  int total = 0;
  int bad   = 0;

  logic          m_valid, m_vc;
  logic [BN-1:0] m_data;
  int            m_streak;
  logic          e_g0, e_g1;
  logic [BN-1:0] saved;

  vc_arbiter #(.BITNUMBER(BN), .WEIGHT(W)) dut (
    .clk(clk), .reset(reset),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .valid_out(valid_out), .data_out(data_out), .active_vc(active_vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_vc     = 1'b0;
    m_data   = '0;
    m_streak = 0;
  endtask

  // Expected grant from the current inputs, following the arbitration rules directly.
  task automatic model_grant();
    logic ok0, ok1;
    ok0 = !vc0_empty && ((vc0_data[BN-1] == 1'b1) ? !d1_pause : !d0_pause);
    ok1 = !vc1_empty && ((vc1_data[BN-1] == 1'b1) ? !d1_pause : !d0_pause);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (ok0 && ok1) begin
`ifdef VC_ARB_WRR_EN
      if (m_streak < W) e_g0 = 1'b1; else e_g1 = 1'b1;
`else
      e_g0 = 1'b1;
`endif
    end else begin
      e_g0 = ok0;
      e_g1 = ok1;
    end
  endtask

  task automatic drive(input logic emp0, input logic emp1, input logic [BN-1:0] dat0,
                       input logic [BN-1:0] dat1, input logic p0, input logic p1);
    vc0_empty = emp0;
    vc1_empty = emp1;
    vc0_data  = dat0;
    vc1_data  = dat1;
    d0_pause  = p0;
    d1_pause  = p1;
    #1;
  endtask

  // Check pops now, clock once, then check the registered outputs on the falling edge.
  task automatic cycle(input string tag);
    model_grant();
    chk({tag, ".vc0_pop"}, 32'(vc0_pop), 32'(e_g0));
    chk({tag, ".vc1_pop"}, 32'(vc1_pop), 32'(e_g1));
    @(posedge clk);
    if (e_g0) begin
      m_valid = 1'b1; m_data = vc0_data; m_vc = 1'b0;
      m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
    end else if (e_g1) begin
      m_valid = 1'b1; m_data = vc1_data; m_vc = 1'b1; m_streak = 0;
    end else begin
      m_valid = 1'b0; m_streak = 0;
    end
    @(negedge clk);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".data_out"},  32'(data_out),  32'(m_data));
    chk({tag, ".active_vc"}, 32'(active_vc), 32'(m_vc));
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 5'b00011, 5'b00100, 1'b0, 1'b0);
    chk("rst.valid_out", 32'(valid_out), 0);
    chk("rst.data_out",  32'(data_out),  0);
    chk("rst.active_vc", 32'(active_vc), 0);
    chk("rst.vc0_pop",   32'(vc0_pop),   0);
    chk("rst.vc1_pop",   32'(vc1_pop),   0);
    @(negedge clk);
    reset = 1'b1;

    // Single VC0 word, latency 1
    drive(1'b0, 1'b1, 5'b00011, 5'b00000, 1'b0, 1'b0);
    chk("single.pop_now", 32'(vc0_pop), 1);
    cycle("single");
    chk("single.data", 32'(data_out), 32'(5'b00011));
    chk("single.valid", 32'(valid_out), 1);
    chk("single.vc", 32'(active_vc), 0);

    // Head-of-line: VC0 head targets paused dest1, VC1 still served
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'b10001, 5'b00100, 1'b0, 1'b1);
      chk("hol.vc0_blocked", 32'(vc0_pop), 0);
      chk("hol.vc1_served", 32'(vc1_pop), 1);
      cycle("hol");
    end
    drive(1'b0, 1'b0, 5'b10001, 5'b00100, 1'b0, 1'b0);
    chk("hol.release", 32'(vc0_pop), 1);
    cycle("hol_rel");

    // Both empty: no grant, data_out holds
    saved = data_out;
    drive(1'b1, 1'b1, 5'b01010, 5'b10101, 1'b0, 1'b0);
    chk("empty.pops", 32'({vc0_pop, vc1_pop}), 0);
    cycle("empty");
    chk("empty.hold", 32'(data_out), 32'(saved));
    chk("empty.valid", 32'(valid_out), 0);

    // Both always non-empty, starting from a cleared streak
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, BN'(i), BN'(i + 8), 1'b0, 1'b0);
`ifdef VC_ARB_WRR_EN
      chk("wrr.pattern", 32'(vc1_pop), 32'((i % 5) == 4));
`else
      chk("sp.pattern", 32'(vc1_pop), 0);
`endif
      cycle("both");
    end

    // Randomized traffic with a mid-stream async reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            BN'($urandom), BN'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      cycle("rand");
      if (i == 200) begin
        drive(1'b0, 1'b1, 5'b00111, 5'b00000, 1'b0, 1'b0);
        cycle("pre_rst");
        chk("pre_rst.valid", 32'(valid_out), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst.valid_out", 32'(valid_out), 0);
        chk("midrst.data_out",  32'(data_out),  0);
        chk("midrst.active_vc", 32'(active_vc), 0);
        chk("midrst.pops", 32'({vc0_pop, vc1_pop}), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 The block SHALL have parameter BITNUMBER, default 5, giving the word width; bit BITNUMBER-1 is the destination bit (0 = dest0, 1 = dest1).
REQ-002 The block SHALL have parameter WEIGHT, default 4, giving the maximum consecutive VC0 grants while VC1 is waiting; legal range 1-15.
REQ-003 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous reset, active-low.
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_data  input  BITNUMBER  VC0 FIFO head word, valid whenever vc0_empty=0 (show-ahead).
- vc1_data  input  BITNUMBER  VC1 FIFO head word, valid whenever vc1_empty=0 (show-ahead).
- d0_pause  input  1  dest0 FIFO almost-full; no word for dest0 may be popped.
- d1_pause  input  1  dest1 FIFO almost-full; no word for dest1 may be popped.
- vc0_pop  output  1  combinational pop strobe to the VC0 FIFO.
- vc1_pop  output  1  combinational pop strobe to the VC1 FIFO.
- valid_out  output  1  registered; data_out holds a granted word.
- data_out  output  BITNUMBER  registered granted word, fed to the destination mux.
- active_vc  output  1  registered; VC of the word on data_out.

Function
REQ-004 A VC SHALL be eligible in a cycle iff its FIFO is not empty and the pause input for its head word's destination bit is 0.
REQ-005 At most one of vc0_pop and vc1_pop SHALL be 1 in any cycle; the asserted pop SHALL be the granted eligible VC.
REQ-006 The granted head word SHALL appear on data_out with valid_out=1 and active_vc set one cycle after the pop (latency 1); with no grant, valid_out SHALL be 0 and data_out SHALL hold its last value.
REQ-007 The FSM SHALL have states IDLE (no eligible VC), SERVE_VC0 (last grant VC0) and SERVE_VC1 (last grant VC1).
REQ-008 The FSM SHALL move to SERVE_VC0 or SERVE_VC1 on each grant to that VC, and to IDLE in any cycle with no grant.
REQ-009 A 4-bit counter wcnt SHALL increment on each VC0 grant, clear on any VC1 grant, and clear in IDLE.
REQ-010 When only one VC is eligible, it SHALL be granted regardless of wcnt or state.
REQ-011 When both VCs are eligible, arbitration SHALL follow REQ-016/REQ-017.
REQ-012 A paused head word SHALL block only its own VC (head-of-line); the other VC SHALL still be granted if eligible.
REQ-013 A pause or empty input that changes in a cycle SHALL be honoured in that same cycle (pops are combinational on the current inputs).
REQ-014 wcnt SHALL saturate at 15 and SHALL never wrap.

Reset
REQ-015 While reset=0, the block SHALL asynchronously force state=IDLE, wcnt=0, valid_out=0, data_out=0 and active_vc=0, and SHALL hold vc0_pop=0 and vc1_pop=0; reset asserted mid-transfer SHALL drop valid_out immediately, and arbitration SHALL resume on the first rising clk edge after reset=1.

Configuration
REQ-016 With macro VC_ARB_WRR_EN defined, and both VCs eligible: VC0 SHALL be granted while wcnt<WEIGHT, else VC1 SHALL be granted (weighted round-robin, WEIGHT:1).
REQ-017 Without VC_ARB_WRR_EN, and both VCs eligible: VC0 SHALL always be granted (strict priority); wcnt SHALL be absent or held at 0.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- Reset low mid-stream -> all outputs 0 asynchronously, before the next clk edge.
- VC0 holds 5'b00011, VC1 empty, no pause -> vc0_pop=1 in cycle n; data_out=5'b00011, valid_out=1, active_vc=0 in cycle n+1.
- VC0 head 5'b10001, d1_pause=1, VC1 head 5'b00100 -> vc1_pop=1 only; vc0_pop=0 until d1_pause=0.
- Both VCs always non-empty, no pause, VC_ARB_WRR_EN, WEIGHT=4 -> grant pattern 0,0,0,0,1 repeating.
- Same stimulus without VC_ARB_WRR_EN -> VC0 granted every cycle; vc1_pop never 1.
- Both FIFOs empty -> state=IDLE, both pops 0, valid_out=0, data_out unchanged.
